dmem_responder: RTL and testbench

- Data-memory target that answers load/store requests from the CPU memory stage over a valid/ready request channel and a valid/ready response channel.
- Models a word-addressed RAM with byte enables and a fixed, parameterised access latency, so the pipeline can be exercised against a non-single-cycle memory.
- Holds one request in flight at a time.
- Flags misaligned and out-of-range accesses with an error response.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response channel between the CPU memory stage and the data-memory responder.
interface dmem_responder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [3:0]       req_be;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM with byte enables, fixed access latency and one request in flight.
// Commit (RAM write or read capture) happens on the edge that enters RESP.
module dmem_responder #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  dmem_responder_if.slave    bus
);
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [WIDTH-1:0] ADDR_LIM = WIDTH'(DEPTH * 4);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept_c, commit_c;

  logic             cap_we, cap_err;
  logic [IDX_W-1:0] cap_idx;
  logic [WIDTH-1:0] cap_wdata;
  logic [3:0]       cap_be;

  logic             in_err_c;
  logic             c_we, c_err;
  logic [IDX_W-1:0] c_idx;
  logic [WIDTH-1:0] c_wdata;
  logic [3:0]       c_be;

  logic [WIDTH-1:0] mem [DEPTH];

  assign in_err_c = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= ADDR_LIM);

  // With LATENCY==1 the commit coincides with the accept edge, so use the live request.
  always_comb begin
    c_we    = cap_we;
    c_err   = cap_err;
    c_idx   = cap_idx;
    c_wdata = cap_wdata;
    c_be    = cap_be;
    if (state == IDLE) begin
      c_we    = bus.req_we;
      c_err   = in_err_c;
      c_idx   = bus.req_addr[IDX_W+1:2];
      c_wdata = bus.req_wdata;
      c_be    = bus.req_be;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept_c   = 1'b0;
    commit_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept_c = 1'b1;
          if (LATENCY == 1) begin
            state_next = RESP;
            commit_c   = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_next = RESP;
          commit_c   = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      cap_we         <= 1'b0;
      cap_err        <= 1'b0;
      cap_idx        <= '0;
      cap_wdata      <= '0;
      cap_be         <= '0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      bus.req_ready  <= (state_next == IDLE);
      bus.resp_valid <= (state_next == RESP);
      if (accept_c) begin
        cap_we    <= bus.req_we;
        cap_err   <= in_err_c;
        cap_idx   <= bus.req_addr[IDX_W+1:2];
        cap_wdata <= bus.req_wdata;
        cap_be    <= bus.req_be;
      end
      if (commit_c) begin
        bus.resp_rdata <= (c_we || c_err) ? '0 : mem[c_idx];
        bus.resp_err   <= c_err;
      end
    end
  end

  // RAM is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && commit_c && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_dmem_responder;
  localparam int unsigned LAT_A = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t qa [$];
  exp_t qb [$];

  always #5 clk = ~clk;

  dmem_responder_if #(.WIDTH(32)) a_if ();
  dmem_responder_if #(.WIDTH(32)) b_if ();

  dmem_responder #(.WIDTH(32), .DEPTH(1024), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );
  dmem_responder #(.WIDTH(32), .DEPTH(1024), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One LATENCY=2 transaction, called at a negedge with the DUT idle; bp = cycles of backpressure.
  task automatic a_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] er, input logic ee, input int bp);
    exp_t e;
    int   n;
    qa.push_back('{rdata: er, err: ee});
    chk("a_req_ready_idle", 32'(a_if.req_ready), 32'd1);
    a_if.req_we    = we;
    a_if.req_addr  = addr;
    a_if.req_wdata = wdata;
    a_if.req_be    = be;
    a_if.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_if.req_valid  = 1'b0;
    a_if.resp_ready = 1'b0;
    n = 1;
    while (!a_if.resp_valid && n < 20) begin
      chk("a_req_ready_busy", 32'(a_if.req_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("a_latency", 32'(n), 32'(LAT_A));
    e = qa.pop_front();
    for (int i = 0; i < bp; i++) begin
      chk("a_bp_valid", 32'(a_if.resp_valid), 32'd1);
      chk("a_bp_rdata", a_if.resp_rdata, e.rdata);
      chk("a_bp_err", 32'(a_if.resp_err), 32'(e.err));
      chk("a_bp_req_ready", 32'(a_if.req_ready), 32'd0);
      a_if.req_valid = ((i % 2) == 0);
      a_if.req_we    = 1'b1;
      a_if.req_addr  = 32'h40;
      a_if.req_wdata = 32'hBAD0BAD0;
      a_if.req_be    = 4'hF;
      @(negedge clk);
    end
    a_if.req_valid = 1'b0;
    chk("a_resp_valid", 32'(a_if.resp_valid), 32'd1);
    chk("a_rdata", a_if.resp_rdata, e.rdata);
    chk("a_err", 32'(a_if.resp_err), 32'(e.err));
    a_if.resp_ready = 1'b1;
    @(negedge clk);
    a_if.resp_ready = 1'b0;
    chk("a_ready_after_hs", 32'(a_if.req_ready), 32'd1);
    chk("a_valid_after_hs", 32'(a_if.resp_valid), 32'd0);
  endtask

  // LATENCY=1 step with req_valid held high and resp_ready tied high: one accept every 2 cycles.
  task automatic b_step(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] er, input logic ee);
    exp_t e;
    chk("b_req_ready", 32'(b_if.req_ready), 32'd1);
    chk("b_valid_idle", 32'(b_if.resp_valid), 32'd0);
    qb.push_back('{rdata: er, err: ee});
    b_if.req_we    = we;
    b_if.req_addr  = addr;
    b_if.req_wdata = wdata;
    b_if.req_be    = 4'hF;
    b_if.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    e = qb.pop_front();
    chk("b_resp_valid", 32'(b_if.resp_valid), 32'd1);
    chk("b_req_ready_resp", 32'(b_if.req_ready), 32'd0);
    chk("b_rdata", b_if.resp_rdata, e.rdata);
    chk("b_err", 32'(b_if.resp_err), 32'(e.err));
    @(negedge clk);
  endtask

  initial begin
    a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0;
    a_if.req_wdata = '0;   a_if.req_be = '0;   a_if.resp_ready = 1'b0;
    b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = '0;
    b_if.req_wdata = '0;   b_if.req_be = '0;   b_if.resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_req_ready", 32'(a_if.req_ready), 32'd1);
    chk("rst_a_resp_valid", 32'(a_if.resp_valid), 32'd0);
    chk("rst_a_rdata", a_if.resp_rdata, 32'd0);
    chk("rst_a_err", 32'(a_if.resp_err), 32'd0);
    chk("rst_b_req_ready", 32'(b_if.req_ready), 32'd1);
    chk("rst_b_resp_valid", 32'(b_if.resp_valid), 32'd0);
    rst = 1'b1;

    // Known background contents
    a_txn(1'b1, 32'h0,  32'h01234567, 4'hF, 32'h0, 1'b0, 0);
    a_txn(1'b1, 32'h30, 32'h00000000, 4'hF, 32'h0, 1'b0, 0);
    a_txn(1'b1, 32'h40, 32'h40404040, 4'hF, 32'h0, 1'b0, 0);

    a_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    a_txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

    // Byte-lane merge
    a_txn(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
    a_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 0);
    a_txn(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);

    // Errors and empty byte enable
    a_txn(1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    a_txn(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
    a_txn(1'b0, 32'h0, 32'h0, 4'h0, 32'h01234567, 1'b0, 0);
    a_txn(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    a_txn(1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0, 1'b0, 0);
    a_txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

    // Backpressure with ignored request pulses to 0x40
    a_txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 5);
    a_txn(1'b0, 32'h40, 32'h0, 4'h0, 32'h40404040, 1'b0, 0);

    // Reset while the store is in BUSY discards it
    a_if.req_we = 1'b1; a_if.req_addr = 32'h30; a_if.req_wdata = 32'h55;
    a_if.req_be = 4'hF; a_if.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_if.req_valid = 1'b0;
    chk("midrst_busy_ready", 32'(a_if.req_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_resp_valid", 32'(a_if.resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(a_if.req_ready), 32'd1);
    chk("midrst_err", 32'(a_if.resp_err), 32'd0);
    rst = 1'b1;
    a_txn(1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 0);

    // LATENCY=1 back-to-back traffic
    for (int i = 0; i < 4; i++)
      b_step(1'b1, 32'(4 * i), 32'hC0DE0000 + 32'(i), 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      b_step(1'b0, 32'(4 * i), 32'h0, 32'hC0DE0000 + 32'(i), 1'b0);
    b_step(1'b0, 32'h3, 32'h0, 32'h0, 1'b1);
    b_if.req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
